// File: rtl/scroll_pkg.sv
// Shared constants, lane code type and colour decode for the scrolling-lane rhythm video slot.
package scroll_pkg;

  localparam int LANE_COUNT = 8;
  localparam int LANE_WIDE  = 90;
  localparam int FRAME_W    = 720;
  localparam int FRAME_H    = 400;

  localparam logic [11:0] COLOR_NONE   = 12'hFFE;
  localparam logic [11:0] COLOR_CODE_1 = 12'hE34;
  localparam logic [11:0] COLOR_CODE_2 = 12'hADD;
  localparam logic [11:0] COLOR_CODE_3 = 12'h479;

  typedef logic [1:0] lane_code_t;

  // Unknown colours (anti-aliasing, background) read as an empty lane.
  function automatic lane_code_t decode_lane_color(input logic [11:0] rgb);
    case (rgb)
      COLOR_CODE_1: return 2'd1;
      COLOR_CODE_2: return 2'd2;
      COLOR_CODE_3: return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] count_lanes(input logic [LANE_COUNT-1:0] mask);
    count_lanes = '0;
    for (int i = 0; i < LANE_COUNT; i++) count_lanes = count_lanes + 4'(mask[i]);
  endfunction

endpackage

// File: rtl/scroll_hit_judge_key_sync.sv
// Per-lane button synchronizer with a one-cycle rising-edge pulse.
module key_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic edge_pulse
);

  logic sync_1, sync_2, prev, prime_1, prime_2;

  // prime_* mark when sync_2 holds a real sample; until then prev stays high
  // so a button held through reset release cannot look like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      prev       <= 1'b1;
      prime_1    <= 1'b0;
      prime_2    <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_1     <= key_in;
      sync_2     <= sync_1;
      prime_1    <= 1'b1;
      prime_2    <= prime_1;
      prev       <= prime_2 ? sync_2 : 1'b1;
      edge_pulse <= prime_2 & sync_2 & ~prev;
    end
  end

endmodule

// File: rtl/scroll_hit_judge.sv
// Samples lane colours on the judge row, commits them once per frame, and scores button presses.
module scroll_hit_judge
  import scroll_pkg::*;
#(
  parameter logic [10:0] JUDGE_Y_RST = 11'd360,
  parameter logic [15:0] SAT_MAX     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        cs,
  input  logic        write,
  input  logic        read,
  input  logic [13:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [7:0]  key,
  input  logic [11:0] si_rgb,
  output logic [11:0] so_rgb
);

  logic [10:0] judge_y;
  logic [15:0] capture, capture_nxt, snapshot;
  logic [15:0] hit_cnt, miss_cnt, frame_cnt;
  logic        new_flag, overlay_en;
  logic [7:0]  key_pulse, lane_coded, hit_mask, miss_mask;
  logic        row_active, commit, wr_en, clr_cnt, rd_flag;
  logic        unused_bits;

  assign row_active  = (y == judge_y) && (judge_y < 11'(FRAME_H));
  assign commit      = row_active && (x == 11'(FRAME_W - 1));
  assign wr_en       = cs & write;
  assign clr_cnt     = wr_en && (addr[1:0] == 2'd1) && wr_data[0];
  assign rd_flag     = cs && read && (addr[1:0] == 2'd1);
  assign unused_bits = &{1'b0, addr[13:2], wr_data[31:11]};

  for (genvar g = 0; g < LANE_COUNT; g++) begin : g_lane
    key_edge_sync u_key_sync (
      .clk        (clk),
      .reset      (reset),
      .key_in     (key[g]),
      .edge_pulse (key_pulse[g])
    );
    assign lane_coded[g] = (snapshot[2*g +: 2] != 2'd0);
  end

  assign hit_mask  = key_pulse & lane_coded;
  assign miss_mask = key_pulse & ~lane_coded;

  always_comb begin
    capture_nxt = capture;
    for (int l = 0; l < LANE_COUNT; l++)
      if (row_active && (x == 11'(LANE_WIDE * l + LANE_WIDE / 2)))
        capture_nxt[2*l +: 2] = decode_lane_color(si_rgb);
  end

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [3:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {13'b0, inc};
    return (sum > {1'b0, SAT_MAX}) ? SAT_MAX : sum[15:0];
  endfunction

  // Presses are judged against the snapshot as it stood before any same-cycle commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      judge_y    <= JUDGE_Y_RST;
      capture    <= '0;
      snapshot   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      frame_cnt  <= '0;
      new_flag   <= 1'b0;
      overlay_en <= 1'b0;
    end else begin
      capture <= capture_nxt;
      if (commit) begin
        snapshot  <= capture;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (commit)       new_flag <= 1'b1;
      else if (rd_flag) new_flag <= 1'b0;
      if (clr_cnt) begin
        hit_cnt  <= '0;
        miss_cnt <= '0;
      end else begin
        hit_cnt  <= sat_add(hit_cnt, count_lanes(hit_mask));
        miss_cnt <= sat_add(miss_cnt, count_lanes(miss_mask));
      end
      if (wr_en && (addr[1:0] == 2'd0)) judge_y    <= wr_data[10:0];
      if (wr_en && (addr[1:0] == 2'd1)) overlay_en <= wr_data[1];
    end
  end

  always_comb begin
    rd_data = '0;
    if (cs) begin
      case (addr[1:0])
        2'd0:    rd_data = {16'h0, snapshot};
        2'd1:    rd_data = {frame_cnt, 14'h0, overlay_en, new_flag};
        2'd2:    rd_data = {16'h0, hit_cnt};
        default: rd_data = {16'h0, miss_cnt};
      endcase
    end
  end

  assign so_rgb = (overlay_en && (y == judge_y) && (x < 11'(FRAME_W))) ? 12'hF00 : si_rgb;

endmodule

// File: tb/tb_scroll_hit_judge.sv
// Scenario-per-task bench for scroll_hit_judge against a frame/press-level reference model.
`timescale 1ns/1ps
module tb_scroll_hit_judge;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        cs, write, read;
  logic [13:0] addr;
  logic [31:0] wr_data, rd_data;
  logic [7:0]  key;
  logic [11:0] si_rgb, so_rgb;

  scroll_hit_judge #(.JUDGE_Y_RST(11'd360), .SAT_MAX(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write), .read(read),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .key(key),
    .si_rgb(si_rgb), .so_rgb(so_rgb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: lane codes per frame, press tallies, register fields.
  logic [1:0]  m_code [8];
  logic [1:0]  m_cap [8];
  int          m_hit, m_miss, m_frame, m_judge_y;
  bit          m_flag, m_overlay;
  logic [11:0] row_col [8];
  int          ovl_err;

  function automatic logic [1:0] ref_code(input logic [11:0] c);
    if (c == 12'hE34) return 2'd1;
    if (c == 12'hADD) return 2'd2;
    if (c == 12'h479) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [31:0] exp_reg(input int a);
    logic [31:0] r;
    r = '0;
    case (a)
      0: for (int i = 0; i < 8; i++) r[2*i +: 2] = m_code[i];
      1: r = {m_frame[15:0], 14'h0, m_overlay, m_flag};
      2: r = {16'h0, m_hit[15:0]};
      default: r = {16'h0, m_miss[15:0]};
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_code[i] = 2'd0; m_cap[i] = 2'd0; end
    m_hit = 0; m_miss = 0; m_frame = 0; m_judge_y = 360; m_flag = 0; m_overlay = 0;
  endtask

  task automatic model_commit();
    for (int i = 0; i < 8; i++) m_code[i] = m_cap[i];
    m_frame = m_frame + 1;
    m_flag = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input int a, output logic [31:0] d);
    cs = 1; read = 1; addr = {12'($urandom), 2'(a)};
    #2;
    d = rd_data;
    step();
    cs = 0; read = 0;
    if (a == 1) m_flag = 0;
  endtask

  task automatic write_reg(input int a, input logic [31:0] dat);
    cs = 1; write = 1; addr = {12'($urandom), 2'(a)}; wr_data = dat;
    step();
    cs = 0; write = 0;
    if (a == 0) m_judge_y = int'(dat[10:0]);
    else if (a == 1) begin
      if (dat[0]) begin m_hit = 0; m_miss = 0; end
      m_overlay = dat[1];
    end
  endtask

  task automatic press(input logic [7:0] mask);
    key = mask;
    step();
    key = 8'h0;
    repeat (6) step();
    for (int i = 0; i < 8; i++)
      if (mask[i]) begin
        if (m_code[i] != 2'd0) m_hit = (m_hit >= 65535) ? 65535 : m_hit + 1;
        else m_miss = (m_miss >= 65535) ? 65535 : m_miss + 1;
      end
  endtask

  task automatic pick_colors(input bit coded_only);
    for (int i = 0; i < 8; i++) begin
      int p;
      p = coded_only ? $urandom_range(1, 3) : $urandom_range(0, 4);
      case (p)
        0: row_col[i] = 12'hFFE;
        1: row_col[i] = 12'hE34;
        2: row_col[i] = 12'hADD;
        3: row_col[i] = 12'h479;
        default: row_col[i] = 12'($urandom);
      endcase
    end
  endtask

  // Drives one scanline span; non-centre pixels carry random noise.
  task automatic sweep_row(input int yy, input int x_lo, input int x_hi);
    y = 11'(yy);
    for (int xx = x_lo; xx <= x_hi; xx++) begin
      int ln;
      logic [11:0] px, exp_px;
      ln = (xx < 720 && xx % 90 == 45) ? xx / 90 : -1;
      px = (ln >= 0) ? row_col[ln] : 12'($urandom);
      x = 11'(xx);
      si_rgb = px;
      #2;
      exp_px = (m_overlay && yy == m_judge_y && xx < 720) ? 12'hF00 : px;
      if (so_rgb !== exp_px) ovl_err++;
      if (yy == m_judge_y && m_judge_y < 400) begin
        if (ln >= 0) m_cap[ln] = ref_code(px);
        if (xx == 719) model_commit();
      end
      step();
    end
    x = 11'd800;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    for (int a = 0; a < 4; a++) begin
      e = exp_reg(a);
      read_reg(a, d);
      total++;
      if (d !== 32'h0 || d !== e) begin bad++; $display("FAIL reset_reg%0d got=%h want=%h", a, d, e); end
    end
    si_rgb = 12'h5A5; y = 11'd360; x = 11'd100;
    #2;
    total++;
    if (so_rgb !== 12'h5A5) begin bad++; $display("FAIL reset_passthru got=%h want=%h", so_rgb, 12'h5A5); end
    x = 11'd800;
    step();
  endtask

  task automatic test_capture_scenario();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) row_col[i] = 12'hFFE;
    row_col[2] = 12'hE34;
    row_col[5] = 12'h479;
    sweep_row(360, 0, 600);
    read_reg(0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL capture_hidden got=%h want=%h", d, 32'h0); end
    sweep_row(360, 601, 719);
    read_reg(0, d);
    total++;
    if (d !== 32'h0000_0C10 || d !== exp_reg(0)) begin bad++; $display("FAIL snapshot got=%h want=%h", d, 32'h0C10); end
    read_reg(1, d);
    total++;
    if (d !== 32'h0001_0001) begin bad++; $display("FAIL status_after_commit got=%h want=%h", d, 32'h00010001); end
  endtask

  task automatic test_press();
    logic [31:0] d;
    key = 8'h0C;
    step();
    key = 8'h00;
    step();
    read_reg(2, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL press_early got=%h want=%h", d, 32'h0); end
    repeat (4) step();
    m_hit = 1; m_miss = 1;
    read_reg(2, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL press_hit got=%h want=%h", d, 32'h1); end
    read_reg(3, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL press_miss got=%h want=%h", d, 32'h1); end
    cs = 0; addr = 14'd2;
    #2;
    total++;
    if (rd_data !== 32'h0) begin bad++; $display("FAIL cs_low_read got=%h want=%h", rd_data, 32'h0); end
    step();
  endtask

  task automatic test_flag_collision();
    logic [31:0] d, e;
    pick_colors(0);
    sweep_row(360, 0, 718);
    x = 11'd719; si_rgb = 12'($urandom);
    e = exp_reg(1);
    read_reg(1, d);
    model_commit();
    x = 11'd800;
    total++;
    if (d !== e) begin bad++; $display("FAIL collide_read got=%h want=%h", d, e); end
    e = exp_reg(1);
    read_reg(1, d);
    total++;
    if (d !== e || d[0] !== 1'b1) begin bad++; $display("FAIL flag_kept got=%h want=%h", d, e); end
    e = exp_reg(1);
    read_reg(1, d);
    total++;
    if (d !== e || d[0] !== 1'b0) begin bad++; $display("FAIL flag_cleared got=%h want=%h", d, e); end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    for (int it = 0; it < 4; it++) begin
      write_reg(0, 32'($urandom_range(0, 399)));
      pick_colors(0);
      sweep_row(m_judge_y, 0, 719);
      pick_colors(0);
      sweep_row((m_judge_y + 1) % 400, 0, 719);
      for (int a = 0; a < 2; a++) begin
        e = exp_reg(a);
        read_reg(a, d);
        total++;
        if (d !== e) begin bad++; $display("FAIL rand%0d_reg%0d got=%h want=%h", it, a, d, e); end
      end
      for (int p = 0; p < 3; p++) press(8'($urandom_range(1, 255)));
      write_reg($urandom_range(2, 3), $urandom);
      for (int a = 2; a < 4; a++) begin
        e = exp_reg(a);
        read_reg(a, d);
        total++;
        if (d !== e) begin bad++; $display("FAIL rand%0d_reg%0d got=%h want=%h", it, a, d, e); end
      end
    end
    write_reg(0, 32'd360);
  endtask

  task automatic test_overlay();
    logic [31:0] d, e;
    write_reg(1, 32'd3);
    e = exp_reg(1);
    read_reg(1, d);
    total++;
    if (d !== e || d[1] !== 1'b1) begin bad++; $display("FAIL overlay_status got=%h want=%h", d, e); end
    for (int a = 2; a < 4; a++) begin
      read_reg(a, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL overlay_clear_reg%0d got=%h want=%h", a, d, 32'h0); end
    end
    ovl_err = 0;
    pick_colors(0);
    sweep_row(360, 0, 730);
    total++;
    if (ovl_err !== 0) begin bad++; $display("FAIL overlay_row360 bad_pixels=%0d want=0", ovl_err); end
    ovl_err = 0;
    sweep_row(361, 0, 719);
    total++;
    if (ovl_err !== 0) begin bad++; $display("FAIL overlay_row361 bad_pixels=%0d want=0", ovl_err); end
    e = exp_reg(0);
    read_reg(0, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL overlay_snapshot got=%h want=%h", d, e); end
    write_reg(1, 32'd0);
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    logic [31:0] want [3];
    logic [7:0]  masks [3];
    pick_colors(1);
    sweep_row(360, 0, 719);
    write_reg(1, 32'd1);
    for (int n = 0; n < 8191; n++) begin
      key = 8'hFF; step();
      key = 8'h00; step();
    end
    repeat (6) step();
    m_hit = (m_hit + 8 * 8191 > 65535) ? 65535 : m_hit + 8 * 8191;
    read_reg(2, d);
    total++;
    if (d !== exp_reg(2)) begin bad++; $display("FAIL sat_bulk got=%h want=%h", d, exp_reg(2)); end
    masks[0] = 8'h3F; masks[1] = 8'hFF; masks[2] = 8'h01;
    want[0] = 32'hFFFE; want[1] = 32'hFFFF; want[2] = 32'hFFFF;
    for (int k = 0; k < 3; k++) begin
      press(masks[k]);
      read_reg(2, d);
      total++;
      if (d !== want[k] || d !== exp_reg(2)) begin bad++; $display("FAIL sat_step%0d got=%h want=%h", k, d, want[k]); end
    end
    read_reg(3, d);
    total++;
    if (d !== exp_reg(3)) begin bad++; $display("FAIL sat_miss got=%h want=%h", d, exp_reg(3)); end
    key = 8'h81; step();
    key = 8'h00; step();
    cs = 1; write = 1; addr = 14'd1; wr_data = 32'd1;
    step(); step();
    cs = 0; write = 0;
    m_hit = 0; m_miss = 0; m_overlay = 0;
    repeat (4) step();
    read_reg(2, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL clear_beats_inc got=%h want=%h", d, 32'h0); end
  endtask

  task automatic test_reset_key_held();
    logic [31:0] d, e;
    key = 8'h01;
    pick_colors(1);
    sweep_row(360, 0, 400);
    #2 reset = 1;
    model_reset();
    step(); step();
    reset = 0;
    repeat (8) step();
    for (int a = 2; a < 4; a++) begin
      read_reg(a, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL held_key_reg%0d got=%h want=%h", a, d, 32'h0); end
    end
    key = 8'h00;
    repeat (3) step();
    pick_colors(1);
    sweep_row(360, 500, 719);
    for (int a = 0; a < 2; a++) begin
      e = exp_reg(a);
      read_reg(a, d);
      total++;
      if (d !== e) begin bad++; $display("FAIL partial_reg%0d got=%h want=%h", a, d, e); end
    end
    write_reg(0, 32'd500);
    sweep_row(500, 0, 719);
    write_reg(0, 32'd400);
    sweep_row(400, 0, 719);
    e = exp_reg(1);
    read_reg(1, d);
    total++;
    if (d !== e || d[31:16] !== 16'd1) begin bad++; $display("FAIL offscreen_judge got=%h want=%h", d, e); end
  endtask

  initial begin
    reset = 1; x = 11'd800; y = 11'd0; cs = 0; write = 0; read = 0;
    addr = '0; wr_data = '0; key = '0; si_rgb = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    step();
    test_reset();
    test_capture_scenario();
    test_press();
    test_flag_collision();
    test_random();
    test_overlay();
    test_saturation();
    test_reset_key_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
